mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master, one-slave arbiter for the native CPU memory bus (valid/ready, addr, wdata, wstrb, rdata). It sits between the CPU (master 0) and a second bus master (master 1, e.g. UART loader or DMA) on one side, and the address decoder feeding BRAM/LED/peripherals on the other. It grants whole transactions with round-robin fairness, holds the grant until the slave answers, and aborts hung transactions with a timeout.

## Interface

Parameters:
- TIMEOUT_CYCLES, 255: cycles in a grant state without slave ready before abort; legal range 1–65535.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned to a master on timeout.

Ports:
- clk  in  1  system clock, one clock domain.
- reset  in  1  asynchronous, active-high reset.
- m0_mem_valid / m1_mem_valid  in  1  transaction request; held until the matching ready.
- m0_mem_instr / m1_mem_instr  in  1  instruction-fetch flag.
- m0_mem_addr / m1_mem_addr  in  32  byte address.
- m0_mem_wdata / m1_mem_wdata  in  32  write data.
- m0_mem_wstrb / m1_mem_wstrb  in  4  byte strobes; 0 = read.
- m0_mem_ready / m1_mem_ready  out  1  transaction complete.
- m0_mem_rdata / m1_mem_rdata  out  32  read data.
- s_mem_valid, s_mem_instr, s_mem_addr[31:0], s_mem_wdata[31:0], s_mem_wstrb[3:0]  out  forwarded request.
- s_mem_ready  in  1; s_mem_rdata  in  32  slave response.
- busy  out  1  high in either grant state.
- timeout_err  out  1  one-cycle pulse on abort.

## Operation

- FSM states: ARB_IDLE, ARB_GRANT0, ARB_GRANT1. Registers: state, last_grant (1 bit), timeout counter (16 bit).
- ARB_IDLE: only m0 valid -> GRANT0; only m1 valid -> GRANT1; both -> grant the master != last_grant; none -> stay.
- In GRANTn: s_mem_valid/instr/addr/wdata/wstrb = master n's signals (combinational mux on state); mn_mem_ready = s_mem_ready; mn_mem_rdata = s_mem_rdata.
- Completion: s_mem_valid && s_mem_ready in GRANTn -> ARB_IDLE, last_grant <= n, counter cleared.
- Master n drops valid while granted (protocol violation): -> ARB_IDLE next edge, last_grant <= n, no ready issued.
- Timeout: counter increments each GRANT cycle without s_mem_ready; when counter == TIMEOUT_CYCLES-1 and ready still low: that cycle s_mem_valid = 0, mn_mem_ready = 1, mn_mem_rdata = ERR_RDATA, timeout_err = 1; -> ARB_IDLE, last_grant <= n.
- Non-granted master always sees ready 0, rdata 0.
- In ARB_IDLE: all s_mem_* outputs 0, both ready 0, both rdata 0.
- Reset (any time, including mid-transaction): state ARB_IDLE, last_grant 1 (m0 wins first tie), counter 0; all outputs 0 immediately; an interrupted transaction is dropped with no ready.

## Timing

- Arbitration latency: request sampled at edge ending ARB_IDLE cycle t; forwarded in cycle t+1.
- Zero-wait slave (ready same cycle as valid): ready to master in cycle t+1.
- Completion in cycle c -> ARB_IDLE in c+1 -> next grant earliest c+2; one idle bubble between transactions, always.
- Contention: grants alternate m0, m1, m0, …; neither master waits more than one other transaction.
- Timeout fires in the TIMEOUT_CYCLES-th grant cycle; slave ready in that same cycle wins (normal completion, no error).
- busy and timeout_err are decoded from state/counter, no extra register stage.

## Structure

- Package mem_bus_pkg: arb_state_t enum (ARB_IDLE, ARB_GRANT0, ARB_GRANT1), default ERR_RDATA constant, bus width constants (32 addr/data, 4 strobe).
- Sub-module mem_bus_timeout: counter with clear/enable inputs and expire output, parameterised by TIMEOUT_CYCLES; everything else in mem_bus_arbiter.

## Test plan

- Single m0 read of 0x0000_0100, slave ready same cycle with rdata 0x1234_5678 -> s_mem_valid in cycle t+1, m0_mem_ready=1 and rdata 0x1234_5678 in t+1, m1_mem_ready never high.
- Both masters request simultaneously after reset, m0 write 0xF000_1000 wstrb 4'b1111, m1 read 0x0000_0000 -> m0 granted first, m1 granted two cycles after m0 completes; next contention grants m1 first? no: grants alternate, third grant goes to m0.
- Slave holds ready low with TIMEOUT_CYCLES=8 -> 8th grant cycle: m0_mem_ready=1, rdata 0xDEAD_BEEF, timeout_err one-cycle pulse, s_mem_valid 0 that cycle, then ARB_IDLE.
- Slave ready asserted exactly in the 8th cycle (TIMEOUT_CYCLES=8) -> normal completion, timeout_err stays 0.
- Assert reset mid-GRANT1 with 3-wait-state slave -> all outputs 0 immediately, no m1 ready; after release, tie between m0 and m1 grants m0.
- m1 drops valid after 2 grant cycles -> return to ARB_IDLE next edge, no ready, pending m0 granted following cycle.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the native CPU memory bus arbiter.
package mem_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   // Read data handed back to a master whose transaction was aborted.
   localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT0 = 2'd1,
      ARB_GRANT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_bus_timeout.sv
// Grant-duration counter: counts grant cycles without a slave answer and
// flags the last cycle before the transaction must be aborted.
module mem_bus_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count;

   // Count waiting cycles; clear has priority so a finished grant starts fresh.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 16'd1;
      end
   end

   // Counter starts at 0 in the first grant cycle, so LAST_COUNT marks the
   // TIMEOUT_CYCLES-th grant cycle.
   assign expire = (count == LAST_COUNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the native memory bus.
// Grants whole transactions and aborts grants the slave never answers.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned        TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0]  ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_mem_valid,
   input  logic              m0_mem_instr,
   input  logic [ADDR_W-1:0] m0_mem_addr,
   input  logic [DATA_W-1:0] m0_mem_wdata,
   input  logic [STRB_W-1:0] m0_mem_wstrb,
   output logic              m0_mem_ready,
   output logic [DATA_W-1:0] m0_mem_rdata,
   input  logic              m1_mem_valid,
   input  logic              m1_mem_instr,
   input  logic [ADDR_W-1:0] m1_mem_addr,
   input  logic [DATA_W-1:0] m1_mem_wdata,
   input  logic [STRB_W-1:0] m1_mem_wstrb,
   output logic              m1_mem_ready,
   output logic [DATA_W-1:0] m1_mem_rdata,
   output logic              s_mem_valid,
   output logic              s_mem_instr,
   output logic [ADDR_W-1:0] s_mem_addr,
   output logic [DATA_W-1:0] s_mem_wdata,
   output logic [STRB_W-1:0] s_mem_wstrb,
   input  logic              s_mem_ready,
   input  logic [DATA_W-1:0] s_mem_rdata,
   output logic              busy,
   output logic              timeout_err
);

   arb_state_t state, next_state;
   logic       last_grant, next_last_grant;
   logic       cnt_clear, cnt_enable, cnt_expire;

   // Request of whichever master the current grant state selects.
   logic              sel;
   logic              g_valid, g_instr;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;
   logic [STRB_W-1:0] g_wstrb;
   logic              g_ready;
   logic [DATA_W-1:0] g_rdata;

   assign sel     = (state == ARB_GRANT1);
   assign g_valid = sel ? m1_mem_valid : m0_mem_valid;
   assign g_instr = sel ? m1_mem_instr : m0_mem_instr;
   assign g_addr  = sel ? m1_mem_addr  : m0_mem_addr;
   assign g_wdata = sel ? m1_mem_wdata : m0_mem_wdata;
   assign g_wstrb = sel ? m1_mem_wstrb : m0_mem_wstrb;

   mem_bus_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .expire (cnt_expire)
   );

   // State and round-robin history registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ARB_IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= next_state;
         last_grant <= next_last_grant;
      end
   end

   // Arbitration, completion/abort decisions and the output mux.
   // NOTE: every output is decoded from state and inputs with no register
   // stage, so asserting reset forces them all to 0 immediately.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      next_state      = state;
      next_last_grant = last_grant;
      cnt_clear       = 1'b1;
      cnt_enable      = 1'b0;
      s_mem_valid     = 1'b0;
      s_mem_instr     = 1'b0;
      s_mem_addr      = '0;
      s_mem_wdata     = '0;
      s_mem_wstrb     = '0;
      g_ready         = 1'b0;
      g_rdata         = '0;
      timeout_err     = 1'b0;
      busy            = 1'b0;

      unique case (state)
         ARB_IDLE: begin
            if (m0_mem_valid && m1_mem_valid) begin
               next_state = last_grant ? ARB_GRANT0 : ARB_GRANT1;
            end else if (m0_mem_valid) begin
               next_state = ARB_GRANT0;
            end else if (m1_mem_valid) begin
               next_state = ARB_GRANT1;
            end
         end
         ARB_GRANT0, ARB_GRANT1: begin
            busy        = 1'b1;
            s_mem_valid = g_valid;
            s_mem_instr = g_instr;
            s_mem_addr  = g_addr;
            s_mem_wdata = g_wdata;
            s_mem_wstrb = g_wstrb;
            g_rdata     = s_mem_rdata;
            if (!g_valid) begin
               // Master abandoned its request: release without a ready.
               next_state      = ARB_IDLE;
               next_last_grant = sel;
            end else if (s_mem_ready) begin
               // Slave answer wins even in the expiring cycle.
               g_ready         = 1'b1;
               next_state      = ARB_IDLE;
               next_last_grant = sel;
            end else if (cnt_expire) begin
               s_mem_valid     = 1'b0;
               g_ready         = 1'b1;
               g_rdata         = ERR_RDATA;
               timeout_err     = 1'b1;
               next_state      = ARB_IDLE;
               next_last_grant = sel;
            end else begin
               cnt_clear  = 1'b0;
               cnt_enable = 1'b1;
            end
         end
         default: next_state = ARB_IDLE;
      endcase
   end

   // Only the granted master sees the response; the other reads 0.
   assign m0_mem_ready = (state == ARB_GRANT0) ? g_ready : 1'b0;
   assign m0_mem_rdata = (state == ARB_GRANT0) ? g_rdata : '0;
   assign m1_mem_ready = (state == ARB_GRANT1) ? g_ready : 1'b0;
   assign m1_mem_rdata = (state == ARB_GRANT1) ? g_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES = 8).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_mem_valid = 0, m0_mem_instr = 0;
   logic [31:0] m0_mem_addr = 0, m0_mem_wdata = 0;
   logic [3:0]  m0_mem_wstrb = 0;
   logic        m0_mem_ready;
   logic [31:0] m0_mem_rdata;
   logic        m1_mem_valid = 0, m1_mem_instr = 0;
   logic [31:0] m1_mem_addr = 0, m1_mem_wdata = 0;
   logic [3:0]  m1_mem_wstrb = 0;
   logic        m1_mem_ready;
   logic [31:0] m1_mem_rdata;
   logic        s_mem_valid, s_mem_instr;
   logic [31:0] s_mem_addr, s_mem_wdata;
   logic [3:0]  s_mem_wstrb;
   logic        s_mem_ready = 0;
   logic [31:0] s_mem_rdata = 0;
   logic        busy, timeout_err;

   int n_vec = 0;
   int n_err = 0;

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES (8),
      .ERR_RDATA      (32'hDEAD_BEEF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .m0_mem_valid (m0_mem_valid),
      .m0_mem_instr (m0_mem_instr),
      .m0_mem_addr  (m0_mem_addr),
      .m0_mem_wdata (m0_mem_wdata),
      .m0_mem_wstrb (m0_mem_wstrb),
      .m0_mem_ready (m0_mem_ready),
      .m0_mem_rdata (m0_mem_rdata),
      .m1_mem_valid (m1_mem_valid),
      .m1_mem_instr (m1_mem_instr),
      .m1_mem_addr  (m1_mem_addr),
      .m1_mem_wdata (m1_mem_wdata),
      .m1_mem_wstrb (m1_mem_wstrb),
      .m1_mem_ready (m1_mem_ready),
      .m1_mem_rdata (m1_mem_rdata),
      .s_mem_valid  (s_mem_valid),
      .s_mem_instr  (s_mem_instr),
      .s_mem_addr   (s_mem_addr),
      .s_mem_wdata  (s_mem_wdata),
      .s_mem_wstrb  (s_mem_wstrb),
      .s_mem_ready  (s_mem_ready),
      .s_mem_rdata  (s_mem_rdata),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; outputs are sampled
   // at the falling edge of the same cycle.
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      m0_mem_valid = 0; m0_mem_instr = 0; m0_mem_addr = 0; m0_mem_wdata = 0; m0_mem_wstrb = 0;
      m1_mem_valid = 0; m1_mem_instr = 0; m1_mem_addr = 0; m1_mem_wdata = 0; m1_mem_wstrb = 0;
      s_mem_ready = 0; s_mem_rdata = 0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      clear_inputs();
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      m0_mem_valid = 1; m1_mem_valid = 1; s_mem_ready = 1; s_mem_rdata = 32'h5555_AAAA;
      mid();
      if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_err++; end n_vec++;
      if (s_mem_valid !== 1'b0) begin $display("FAIL reset_s_valid got %b want 0", s_mem_valid); n_err++; end n_vec++;
      if (m0_mem_ready !== 1'b0 || m1_mem_ready !== 1'b0) begin $display("FAIL reset_ready got %b%b want 00", m0_mem_ready, m1_mem_ready); n_err++; end n_vec++;
      if (m0_mem_rdata !== 32'h0 || m1_mem_rdata !== 32'h0) begin $display("FAIL reset_rdata got %h %h want 0", m0_mem_rdata, m1_mem_rdata); n_err++; end n_vec++;
      cyc();
      mid();
      if (busy !== 1'b0) begin $display("FAIL reset_hold_busy got %b want 0", busy); n_err++; end n_vec++;
      cyc();
      reset = 1'b0;
      clear_inputs();
   endtask

   task automatic test_single_read;
      m0_mem_valid = 1; m0_mem_addr = 32'h0000_0100; m0_mem_wstrb = 4'b0000;
      s_mem_ready = 1; s_mem_rdata = 32'h1234_5678;
      mid();
      if (s_mem_valid !== 1'b0) begin $display("FAIL single_idle_s_valid got %b want 0", s_mem_valid); n_err++; end n_vec++;
      cyc();
      mid();
      if (s_mem_valid !== 1'b1) begin $display("FAIL single_s_valid got %b want 1", s_mem_valid); n_err++; end n_vec++;
      if (s_mem_addr !== 32'h0000_0100) begin $display("FAIL single_s_addr got %h want 00000100", s_mem_addr); n_err++; end n_vec++;
      if (s_mem_wstrb !== 4'b0000) begin $display("FAIL single_s_wstrb got %b want 0000", s_mem_wstrb); n_err++; end n_vec++;
      if (m0_mem_ready !== 1'b1) begin $display("FAIL single_m0_ready got %b want 1", m0_mem_ready); n_err++; end n_vec++;
      if (m0_mem_rdata !== 32'h1234_5678) begin $display("FAIL single_m0_rdata got %h want 12345678", m0_mem_rdata); n_err++; end n_vec++;
      if (m1_mem_ready !== 1'b0 || m1_mem_rdata !== 32'h0) begin $display("FAIL single_m1_quiet got %b %h want 0 0", m1_mem_ready, m1_mem_rdata); n_err++; end n_vec++;
      if (busy !== 1'b1) begin $display("FAIL single_busy got %b want 1", busy); n_err++; end n_vec++;
      cyc();
      m0_mem_valid = 0;
      mid();
      if (busy !== 1'b0 || m0_mem_ready !== 1'b0 || m1_mem_ready !== 1'b0) begin $display("FAIL single_after got busy=%b r0=%b r1=%b want 000", busy, m0_mem_ready, m1_mem_ready); n_err++; end n_vec++;
      clear_inputs();
   endtask

   task automatic test_contention;
      do_reset();
      m0_mem_valid = 1; m0_mem_addr = 32'hF000_1000; m0_mem_wdata = 32'hA5A5_0001; m0_mem_wstrb = 4'b1111;
      m1_mem_valid = 1; m1_mem_addr = 32'h0000_0000; m1_mem_wstrb = 4'b0000;
      s_mem_ready = 1; s_mem_rdata = 32'h0BAD_F00D;
      cyc();
      mid();
      if (s_mem_addr !== 32'hF000_1000 || s_mem_wstrb !== 4'b1111 || s_mem_wdata !== 32'hA5A5_0001) begin
         $display("FAIL cont_grant1_req got %h %b %h want f0001000 1111 a5a50001", s_mem_addr, s_mem_wstrb, s_mem_wdata); n_err++; end n_vec++;
      if (m0_mem_ready !== 1'b1 || m1_mem_ready !== 1'b0) begin $display("FAIL cont_grant1_ready got %b%b want 10", m0_mem_ready, m1_mem_ready); n_err++; end n_vec++;
      cyc();
      m0_mem_valid = 0;
      mid();
      if (busy !== 1'b0 || m1_mem_ready !== 1'b0) begin $display("FAIL cont_bubble1 got busy=%b r1=%b want 00", busy, m1_mem_ready); n_err++; end n_vec++;
      cyc();
      mid();
      if (s_mem_addr !== 32'h0 || s_mem_wstrb !== 4'b0000 || s_mem_valid !== 1'b1) begin $display("FAIL cont_grant2_req got %h %b %b want 00000000 0000 1", s_mem_addr, s_mem_wstrb, s_mem_valid); n_err++; end n_vec++;
      if (m1_mem_ready !== 1'b1 || m1_mem_rdata !== 32'h0BAD_F00D || m0_mem_ready !== 1'b0) begin
         $display("FAIL cont_grant2_resp got r1=%b d1=%h r0=%b want 1 0badf00d 0", m1_mem_ready, m1_mem_rdata, m0_mem_ready); n_err++; end n_vec++;
      cyc();
      m0_mem_valid = 1; m0_mem_addr = 32'h0000_0200; m0_mem_wstrb = 4'b0000;
      m1_mem_addr = 32'h0000_0300;
      mid();
      if (busy !== 1'b0) begin $display("FAIL cont_bubble2 got %b want 0", busy); n_err++; end n_vec++;
      cyc();
      mid();
      if (s_mem_addr !== 32'h0000_0200 || m0_mem_ready !== 1'b1 || m1_mem_ready !== 1'b0) begin
         $display("FAIL cont_grant3 got %h r0=%b r1=%b want 00000200 1 0", s_mem_addr, m0_mem_ready, m1_mem_ready); n_err++; end n_vec++;
      cyc();
      m0_mem_valid = 0;
      mid();
      if (busy !== 1'b0) begin $display("FAIL cont_bubble3 got %b want 0", busy); n_err++; end n_vec++;
      cyc();
      mid();
      if (s_mem_addr !== 32'h0000_0300 || m1_mem_ready !== 1'b1) begin $display("FAIL cont_grant4 got %h r1=%b want 00000300 1", s_mem_addr, m1_mem_ready); n_err++; end n_vec++;
      cyc();
      clear_inputs();
      mid();
      if (busy !== 1'b0) begin $display("FAIL cont_end_busy got %b want 0", busy); n_err++; end n_vec++;
   endtask

   task automatic test_timeout;
      m0_mem_valid = 1; m0_mem_addr = 32'h0000_0400; s_mem_ready = 0; s_mem_rdata = 32'h1111_2222;
      cyc();
      for (int k = 1; k <= 7; k++) begin
         mid();
         if (s_mem_valid !== 1'b1 || m0_mem_ready !== 1'b0 || timeout_err !== 1'b0) begin
            $display("FAIL tmo_wait%0d got v=%b r0=%b err=%b want 1 0 0", k, s_mem_valid, m0_mem_ready, timeout_err); n_err++; end n_vec++;
         cyc();
      end
      mid();
      if (s_mem_valid !== 1'b0) begin $display("FAIL tmo_s_valid got %b want 0", s_mem_valid); n_err++; end n_vec++;
      if (m0_mem_ready !== 1'b1 || m0_mem_rdata !== 32'hDEAD_BEEF) begin $display("FAIL tmo_resp got %b %h want 1 deadbeef", m0_mem_ready, m0_mem_rdata); n_err++; end n_vec++;
      if (timeout_err !== 1'b1 || busy !== 1'b1 || m1_mem_ready !== 1'b0) begin $display("FAIL tmo_err got err=%b busy=%b r1=%b want 1 1 0", timeout_err, busy, m1_mem_ready); n_err++; end n_vec++;
      cyc();
      m0_mem_valid = 0;
      mid();
      if (timeout_err !== 1'b0 || busy !== 1'b0) begin $display("FAIL tmo_after got err=%b busy=%b want 0 0", timeout_err, busy); n_err++; end n_vec++;
      clear_inputs();
   endtask

   task automatic test_ready_at_limit;
      m0_mem_valid = 1; m0_mem_addr = 32'h0000_0500; s_mem_ready = 0;
      cyc();
      for (int k = 1; k <= 7; k++) begin
         mid();
         if (m0_mem_ready !== 1'b0 || timeout_err !== 1'b0) begin $display("FAIL lim_wait%0d got r0=%b err=%b want 0 0", k, m0_mem_ready, timeout_err); n_err++; end n_vec++;
         cyc();
      end
      s_mem_ready = 1; s_mem_rdata = 32'hCAFE_0001;
      mid();
      if (timeout_err !== 1'b0 || s_mem_valid !== 1'b1) begin $display("FAIL lim_no_err got err=%b v=%b want 0 1", timeout_err, s_mem_valid); n_err++; end n_vec++;
      if (m0_mem_ready !== 1'b1 || m0_mem_rdata !== 32'hCAFE_0001) begin $display("FAIL lim_resp got %b %h want 1 cafe0001", m0_mem_ready, m0_mem_rdata); n_err++; end n_vec++;
      cyc();
      clear_inputs();
      mid();
      if (busy !== 1'b0 || timeout_err !== 1'b0) begin $display("FAIL lim_after got busy=%b err=%b want 0 0", busy, timeout_err); n_err++; end n_vec++;
   endtask

   task automatic test_reset_mid_grant;
      m1_mem_valid = 1; m1_mem_addr = 32'h0000_0600; s_mem_ready = 0; s_mem_rdata = 32'h7777_7777;
      cyc();
      mid();
      if (s_mem_addr !== 32'h0000_0600 || busy !== 1'b1) begin $display("FAIL rst_grant1 got %h busy=%b want 00000600 1", s_mem_addr, busy); n_err++; end n_vec++;
      cyc();
      #1 reset = 1'b1;
      #1;
      if (busy !== 1'b0 || s_mem_valid !== 1'b0 || s_mem_addr !== 32'h0) begin $display("FAIL rst_async_req got busy=%b v=%b a=%h want 0 0 0", busy, s_mem_valid, s_mem_addr); n_err++; end n_vec++;
      if (m1_mem_ready !== 1'b0 || m1_mem_rdata !== 32'h0 || timeout_err !== 1'b0) begin
         $display("FAIL rst_async_resp got r1=%b d1=%h err=%b want 0 0 0", m1_mem_ready, m1_mem_rdata, timeout_err); n_err++; end n_vec++;
      cyc();
      s_mem_ready = 1;
      m0_mem_valid = 1; m0_mem_addr = 32'h0000_0700;
      mid();
      if (m1_mem_ready !== 1'b0 || s_mem_valid !== 1'b0) begin $display("FAIL rst_no_ready got r1=%b v=%b want 0 0", m1_mem_ready, s_mem_valid); n_err++; end n_vec++;
      cyc();
      reset = 1'b0; s_mem_ready = 0;
      mid();
      if (busy !== 1'b0) begin $display("FAIL rst_release_idle got %b want 0", busy); n_err++; end n_vec++;
      cyc();
      s_mem_ready = 1; s_mem_rdata = 32'h0000_0707;
      mid();
      if (s_mem_addr !== 32'h0000_0700 || m0_mem_ready !== 1'b1 || m1_mem_ready !== 1'b0) begin
         $display("FAIL rst_tie_m0 got %h r0=%b r1=%b want 00000700 1 0", s_mem_addr, m0_mem_ready, m1_mem_ready); n_err++; end n_vec++;
      cyc();
      clear_inputs();
   endtask

   task automatic test_drop_valid;
      m0_mem_valid = 1; m0_mem_addr = 32'h0000_0800;
      m1_mem_valid = 1; m1_mem_addr = 32'h0000_0900; s_mem_ready = 0;
      cyc();
      mid();
      if (s_mem_addr !== 32'h0000_0900 || m0_mem_ready !== 1'b0) begin $display("FAIL drop_grant_m1 got %h r0=%b want 00000900 0", s_mem_addr, m0_mem_ready); n_err++; end n_vec++;
      cyc();
      mid();
      if (busy !== 1'b1 || m1_mem_ready !== 1'b0) begin $display("FAIL drop_wait got busy=%b r1=%b want 1 0", busy, m1_mem_ready); n_err++; end n_vec++;
      cyc();
      m1_mem_valid = 0;
      mid();
      if (s_mem_valid !== 1'b0 || m1_mem_ready !== 1'b0 || timeout_err !== 1'b0) begin
         $display("FAIL drop_cycle got v=%b r1=%b err=%b want 0 0 0", s_mem_valid, m1_mem_ready, timeout_err); n_err++; end n_vec++;
      cyc();
      mid();
      if (busy !== 1'b0 || m0_mem_ready !== 1'b0) begin $display("FAIL drop_idle got busy=%b r0=%b want 0 0", busy, m0_mem_ready); n_err++; end n_vec++;
      cyc();
      s_mem_ready = 1; s_mem_rdata = 32'h0000_0808;
      mid();
      if (s_mem_addr !== 32'h0000_0800 || m0_mem_ready !== 1'b1 || m0_mem_rdata !== 32'h0000_0808) begin
         $display("FAIL drop_m0_grant got %h r0=%b d0=%h want 00000800 1 00000808", s_mem_addr, m0_mem_ready, m0_mem_rdata); n_err++; end n_vec++;
      cyc();
      clear_inputs();
      mid();
      if (busy !== 1'b0) begin $display("FAIL drop_end got %b want 0", busy); n_err++; end n_vec++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_timeout();
      test_ready_at_limit();
      test_reset_mid_grant();
      test_drop_valid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
